// File: rtl/mem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
// Contents:
//   state_t        - arbiter FSM states (IDLE, ACCESS, RESP)
//   owner_t        - master encoding (M0 = core, M1 = loader/DMA/debug)
//   DEFAULT_ADDR_W - default memory address width
//   addr_oor()     - true when an address has bits set above the memory range
package mem_arb_pkg;

  localparam int DEFAULT_ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } owner_t;

  // A full 32-bit memory has no out-of-range addresses, so the mask
  // collapses to zero instead of shifting by the full word width.
  function automatic logic addr_oor(input logic [31:0] addr, input int aw);
    logic [31:0] hi_mask;
    hi_mask = (aw >= 32) ? 32'd0 : ~((32'd1 << aw) - 32'd1);
    return |(addr & hi_mask);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of every signal between the two masters, the arbiter and the
// single-port data memory.
// Modports:
//   slave  - the arbiter: takes master commands and memory read data,
//            drives gnt/done/err/rdata and the memory W/realaddr/dout
//   master - the environment around the arbiter (masters + memory)
interface mem_arbiter_if #(
  parameter int ADDR_W = mem_arb_pkg::DEFAULT_ADDR_W
);

  logic              m0_req;
  logic              m0_we;
  logic [31:0]       m0_addr;
  logic [31:0]       m0_wdata;
  logic              m0_gnt;
  logic              m0_done;
  logic              m0_err;
  logic [31:0]       m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [31:0]       m1_addr;
  logic [31:0]       m1_wdata;
  logic              m1_gnt;
  logic              m1_done;
  logic              m1_err;
  logic [31:0]       m1_rdata;

  logic              W;
  logic [ADDR_W-1:0] realaddr;
  logic [31:0]       dout;
  logic [31:0]       din;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  din,
    output m0_gnt, m0_done, m0_err, m0_rdata,
    output m1_gnt, m1_done, m1_err, m1_rdata,
    output W, realaddr, dout
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output din,
    input  m0_gnt, m0_done, m0_err, m0_rdata,
    input  m1_gnt, m1_done, m1_err, m1_rdata,
    input  W, realaddr, dout
  );

endinterface

// File: rtl/mem_arbiter_arb_rr2.sv
// Combinational two-way picker for the memory arbiter.
// Ports:
//   req         in  2  request pair, bit 0 = m0, bit 1 = m1
//   last_owner  in  1  master that won the previous access
//   rr          in  1  1 = round-robin ties, 0 = m0 always wins ties
//   grant_valid out 1  at least one master is requesting
//   winner      out 1  selected master (meaningful only with grant_valid)
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last_owner,
  input  logic       rr,
  output logic       grant_valid,
  output owner_t     winner
);

  // A lone requester always wins; a tie goes to whoever did not win last
  // time in round-robin mode, otherwise to the core.
  always_comb begin
    grant_valid = |req;
    winner      = M0;
    case (req)
      2'b01:   winner = M0;
      2'b10:   winner = M1;
      2'b11:   winner = (rr && (last_owner == M0)) ? M1 : M0;
      default: winner = M0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port 32-bit data memory between the core (m0) and a
// second requester (m1). One access takes ACCESS + RESP; a request seen
// in RESP is re-arbitrated immediately, giving one access per 2 cycles.
// Ports:
//   clk    in  system clock, all state on the rising edge
//   reset  in  synchronous active-high reset
//   bus    slave modport of mem_arbiter_if: m0/m1 command and response
//          signals plus the memory W/realaddr/dout/din connection
// Parameters:
//   ADDR_W memory address width; higher address bits flag an error
//   RR     1 = round-robin on ties, 0 = m0 always wins
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int RR     = 1
) (
  input logic         clk,
  input logic         reset,
  mem_arbiter_if.slave bus
);

  localparam logic RR_BIT = (RR != 0);

  state_t            state_q, state_d;
  owner_t            owner_q, last_owner_q, winner;
  logic              grant_valid, take;
  logic              is_wr_q, oor_q, w_q;
  logic [1:0]        gnt_q;
  logic [ADDR_W-1:0] realaddr_q;
  logic [31:0]       dout_q;
  logic [31:0]       rdata0_q, rdata1_q;

  logic              sel_we, sel_oor;
  logic [31:0]       sel_addr, sel_wdata;
  logic              resp_load;
  logic [31:0]       resp_data;

  arb_rr2 u_pick (
    .req         ({bus.m1_req, bus.m0_req}),
    .last_owner  (last_owner_q),
    .rr          (RR_BIT),
    .grant_valid (grant_valid),
    .winner      (winner)
  );

  // Command fields of whichever master wins this cycle's arbitration.
  always_comb begin
    sel_we    = (winner == M1) ? bus.m1_we    : bus.m0_we;
    sel_addr  = (winner == M1) ? bus.m1_addr  : bus.m0_addr;
    sel_wdata = (winner == M1) ? bus.m1_wdata : bus.m0_wdata;
    sel_oor   = addr_oor(sel_addr, ADDR_W);
  end

  // Next-state logic: arbitration happens in IDLE and again in RESP so a
  // waiting master is picked up without an idle bubble.
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          take    = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        if (grant_valid) begin
          take    = 1'b1;
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and command registers. Reset drops any in-flight access, forces
  // W low and hands the first tie back to m0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= M0;
      last_owner_q <= M1;
      is_wr_q      <= 1'b0;
      oor_q        <= 1'b0;
      w_q          <= 1'b0;
      gnt_q        <= 2'b00;
      realaddr_q   <= '0;
      dout_q       <= 32'd0;
    end else begin
      state_q <= state_d;
      if (take) begin
        realaddr_q   <= sel_addr[ADDR_W-1:0];
        dout_q       <= sel_wdata;
        owner_q      <= winner;
        last_owner_q <= winner;
        is_wr_q      <= sel_we;
        oor_q        <= sel_oor;
        w_q          <= sel_we & ~sel_oor;
        gnt_q        <= (winner == M1) ? 2'b10 : 2'b01;
      end else begin
        w_q   <= 1'b0;
        gnt_q <= 2'b00;
      end
    end
  end

  // Memory read data only arrives during RESP, so the owner's rdata is
  // passed straight through then and captured at the end of RESP to be
  // held afterwards. Out-of-range accesses return zero; writes leave
  // rdata untouched.
  always_comb begin
    resp_load = (state_q == RESP) && (oor_q || !is_wr_q);
    resp_data = oor_q ? 32'd0 : bus.din;
  end

  // Held read data per master.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata0_q <= 32'd0;
      rdata1_q <= 32'd0;
    end else if (resp_load) begin
      if (owner_q == M1) rdata1_q <= resp_data;
      else               rdata0_q <= resp_data;
    end
  end

  // Output drive: strobes come from registers, done/err decode RESP.
  always_comb begin
    bus.W        = w_q;
    bus.realaddr = realaddr_q;
    bus.dout     = dout_q;
    bus.m0_gnt   = gnt_q[0];
    bus.m1_gnt   = gnt_q[1];
    bus.m0_done  = (state_q == RESP) && (owner_q == M0);
    bus.m1_done  = (state_q == RESP) && (owner_q == M1);
    bus.m0_err   = bus.m0_done && oor_q;
    bus.m1_err   = bus.m1_done && oor_q;
    bus.m0_rdata = (resp_load && owner_q == M0) ? resp_data : rdata0_q;
    bus.m1_rdata = (resp_load && owner_q == M1) ? resp_data : rdata1_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. A round-robin instance drives a small
// word memory; a fixed-priority instance sees the same master stimulus so
// contention can be compared between the two modes.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   vectors;
  int   miscompares;

  logic        load_en;
  logic [15:0] load_addr;
  logic [31:0] load_data;
  logic [31:0] mem [0:65535];

  mem_arbiter_if #(.ADDR_W(16)) bus_rr ();
  mem_arbiter_if #(.ADDR_W(16)) bus_fp ();

  mem_arbiter #(.ADDR_W(16), .RR(1)) dut_rr (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_rr.slave)
  );

  mem_arbiter #(.ADDR_W(16), .RR(0)) dut_fp (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_fp.slave)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  // The fixed-priority instance mirrors the round-robin instance's inputs.
  assign bus_fp.m0_req   = bus_rr.m0_req;
  assign bus_fp.m0_we    = bus_rr.m0_we;
  assign bus_fp.m0_addr  = bus_rr.m0_addr;
  assign bus_fp.m0_wdata = bus_rr.m0_wdata;
  assign bus_fp.m1_req   = bus_rr.m1_req;
  assign bus_fp.m1_we    = bus_rr.m1_we;
  assign bus_fp.m1_addr  = bus_rr.m1_addr;
  assign bus_fp.m1_wdata = bus_rr.m1_wdata;
  assign bus_fp.din      = bus_rr.din;

  // Synchronous memory: write on W, read data one cycle after the address,
  // plus a preload port used only while the arbiter is held in reset.
  always @(posedge clk) begin
    if (bus_rr.W) mem[bus_rr.realaddr] <= bus_rr.dout;
    else if (load_en) mem[load_addr] <= load_data;
    bus_rr.din <= mem[bus_rr.realaddr];
  end

  task automatic applyStimulus(input logic r0, input logic w0,
                               input logic [31:0] a0, input logic [31:0] d0,
                               input logic r1, input logic w1,
                               input logic [31:0] a1, input logic [31:0] d1);
    bus_rr.m0_req   = r0;
    bus_rr.m0_we    = w0;
    bus_rr.m0_addr  = a0;
    bus_rr.m0_wdata = d0;
    bus_rr.m1_req   = r1;
    bus_rr.m1_we    = w1;
    bus_rr.m1_addr  = a1;
    bus_rr.m1_wdata = d1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idleMasters();
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    logic m0_turn;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    load_en     = 1'b0;
    load_addr   = 16'd0;
    load_data   = 32'd0;
    idleMasters();

    // Preload memory while reset is held.
    @(negedge clk);
    load_en = 1'b1; load_addr = 16'h0010; load_data = 32'hDEADBEEF;
    @(negedge clk);
    load_addr = 16'h0004; load_data = 32'hA5A5A5A5;
    @(negedge clk);
    load_en = 1'b0;

    // Reset state.
    checkOutput("rst_W",        bus_rr.W,           32'd0);
    checkOutput("rst_m0_gnt",   bus_rr.m0_gnt,      32'd0);
    checkOutput("rst_m1_gnt",   bus_rr.m1_gnt,      32'd0);
    checkOutput("rst_m0_done",  bus_rr.m0_done,     32'd0);
    checkOutput("rst_m1_done",  bus_rr.m1_done,     32'd0);
    checkOutput("rst_m0_err",   bus_rr.m0_err,      32'd0);
    checkOutput("rst_realaddr", 32'(bus_rr.realaddr), 32'd0);
    checkOutput("rst_dout",     bus_rr.dout,        32'd0);
    checkOutput("rst_m0_rdata", bus_rr.m0_rdata,    32'd0);
    checkOutput("rst_m1_rdata", bus_rr.m1_rdata,    32'd0);
    reset = 1'b0;

    // m0 read of 0x0010.
    applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    checkOutput("rd_m0_gnt",    bus_rr.m0_gnt,        32'd1);
    checkOutput("rd_m1_gnt",    bus_rr.m1_gnt,        32'd0);
    checkOutput("rd_realaddr",  32'(bus_rr.realaddr), 32'h0010);
    checkOutput("rd_W",         bus_rr.W,             32'd0);
    checkOutput("rd_early_done", bus_rr.m0_done,      32'd0);
    idleMasters();
    @(negedge clk);
    checkOutput("rd_m0_done",   bus_rr.m0_done,  32'd1);
    checkOutput("rd_m0_err",    bus_rr.m0_err,   32'd0);
    checkOutput("rd_m0_rdata",  bus_rr.m0_rdata, 32'hDEADBEEF);
    checkOutput("rd_gnt_off",   bus_rr.m0_gnt,   32'd0);
    checkOutput("rd_m1_done",   bus_rr.m1_done,  32'd0);
    @(negedge clk);
    checkOutput("rd_done_off",  bus_rr.m0_done,  32'd0);
    checkOutput("rd_hold",      bus_rr.m0_rdata, 32'hDEADBEEF);

    // m0 out-of-range write to 0x00010004.
    applyStimulus(1'b1, 1'b1, 32'h0001_0004, 32'h1111_1111, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    checkOutput("oor_m0_gnt",   bus_rr.m0_gnt,        32'd1);
    checkOutput("oor_W_acc",    bus_rr.W,             32'd0);
    checkOutput("oor_realaddr", 32'(bus_rr.realaddr), 32'h0004);
    idleMasters();
    @(negedge clk);
    checkOutput("oor_W_resp",   bus_rr.W,        32'd0);
    checkOutput("oor_m0_done",  bus_rr.m0_done,  32'd1);
    checkOutput("oor_m0_err",   bus_rr.m0_err,   32'd1);
    checkOutput("oor_m0_rdata", bus_rr.m0_rdata, 32'd0);
    @(negedge clk);
    checkOutput("oor_mem",      mem[16'h0004],   32'hA5A5A5A5);
    checkOutput("oor_err_off",  bus_rr.m0_err,   32'd0);

    // m1 write of 0x12345678 to 0x00FF.
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h0000_00FF, 32'h1234_5678);
    @(negedge clk);
    checkOutput("wr_m1_gnt",    bus_rr.m1_gnt,        32'd1);
    checkOutput("wr_m0_gnt",    bus_rr.m0_gnt,        32'd0);
    checkOutput("wr_W",         bus_rr.W,             32'd1);
    checkOutput("wr_realaddr",  32'(bus_rr.realaddr), 32'h00FF);
    checkOutput("wr_dout",      bus_rr.dout,          32'h1234_5678);
    idleMasters();
    @(negedge clk);
    checkOutput("wr_W_off",     bus_rr.W,        32'd0);
    checkOutput("wr_m1_done",   bus_rr.m1_done,  32'd1);
    checkOutput("wr_m1_err",    bus_rr.m1_err,   32'd0);
    checkOutput("wr_m1_rdata",  bus_rr.m1_rdata, 32'd0);
    checkOutput("wr_m0_done",   bus_rr.m0_done,  32'd0);
    checkOutput("wr_m0_rdata",  bus_rr.m0_rdata, 32'd0);
    @(negedge clk);
    checkOutput("wr_mem",       mem[16'h00FF],   32'h1234_5678);

    // Back-to-back: m0 holds req through RESP with a new address.
    applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    checkOutput("b2b_gnt_a",    bus_rr.m0_gnt,        32'd1);
    checkOutput("b2b_addr_a",   32'(bus_rr.realaddr), 32'h0010);
    applyStimulus(1'b1, 1'b0, 32'h0000_00FF, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    checkOutput("b2b_done_a",   bus_rr.m0_done,  32'd1);
    checkOutput("b2b_rdata_a",  bus_rr.m0_rdata, 32'hDEADBEEF);
    checkOutput("b2b_gnt_off",  bus_rr.m0_gnt,   32'd0);
    @(negedge clk);
    checkOutput("b2b_gnt_b",    bus_rr.m0_gnt,        32'd1);
    checkOutput("b2b_addr_b",   32'(bus_rr.realaddr), 32'h00FF);
    checkOutput("b2b_gap",      bus_rr.m0_done,       32'd0);
    idleMasters();
    @(negedge clk);
    checkOutput("b2b_done_b",   bus_rr.m0_done,  32'd1);
    checkOutput("b2b_rdata_b",  bus_rr.m0_rdata, 32'h1234_5678);
    @(negedge clk);
    checkOutput("b2b_idle",     bus_rr.m0_done,  32'd0);

    // Reset during ACCESS of an m1 write, then both masters contend.
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h0000_0020, 32'hCAFE_F00D);
    @(negedge clk);
    checkOutput("mid_m1_gnt",   bus_rr.m1_gnt, 32'd1);
    checkOutput("mid_W_on",     bus_rr.W,      32'd1);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'd0, 1'b1, 1'b0, 32'h0000_00FF, 32'd0);
    @(negedge clk);
    checkOutput("mid_W_off",    bus_rr.W,       32'd0);
    checkOutput("mid_m1_done",  bus_rr.m1_done, 32'd0);
    checkOutput("mid_m1_gnt0",  bus_rr.m1_gnt,  32'd0);
    checkOutput("mid_fp_W",     bus_fp.W,       32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      m0_turn = (k % 2 == 0);
      checkOutput($sformatf("rr_m0_gnt_%0d", k), bus_rr.m0_gnt, 32'(m0_turn));
      checkOutput($sformatf("rr_m1_gnt_%0d", k), bus_rr.m1_gnt, 32'(!m0_turn));
      checkOutput($sformatf("fp_m0_gnt_%0d", k), bus_fp.m0_gnt, 32'd1);
      checkOutput($sformatf("fp_m1_gnt_%0d", k), bus_fp.m1_gnt, 32'd0);
      @(negedge clk);
      checkOutput($sformatf("rr_gnt_gap_%0d", k),
                  32'(bus_rr.m0_gnt | bus_rr.m1_gnt), 32'd0);
      checkOutput($sformatf("rr_m0_done_%0d", k), bus_rr.m0_done, 32'(m0_turn));
      checkOutput($sformatf("rr_m1_done_%0d", k), bus_rr.m1_done, 32'(!m0_turn));
      if (m0_turn)
        checkOutput($sformatf("rr_m0_rdata_%0d", k), bus_rr.m0_rdata, 32'hDEADBEEF);
      else
        checkOutput($sformatf("rr_m1_rdata_%0d", k), bus_rr.m1_rdata, 32'h1234_5678);
      checkOutput($sformatf("fp_m0_done_%0d", k), bus_fp.m0_done, 32'd1);
      checkOutput($sformatf("fp_m1_done_%0d", k), bus_fp.m1_done, 32'd0);
      if (k == 5) idleMasters();
      @(negedge clk);
    end
    checkOutput("end_m0_gnt",  bus_rr.m0_gnt,  32'd0);
    checkOutput("end_m1_gnt",  bus_rr.m1_gnt,  32'd0);
    checkOutput("end_m0_done", bus_rr.m0_done, 32'd0);
    checkOutput("end_m1_done", bus_rr.m1_done, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
